// File: rtl/gcd_sched.sv
// Round-robin shared subtract-based GCD engine: one requester served at a time,
// one subtraction per clock, result returned with a one-cycle Done pulse.
//   state  | meaning
//   IDLE   | waiting for any Req; grants the next requester after the last one
//   RUN    | iterating xr/yr until one is zero or both are equal
//   DONE   | Done pulse for the grantee, Gcd_out freshly written
module gcd_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic [NREQ-1:0]       Req,
  input  logic [NREQ*WIDTH-1:0] X_in,
  input  logic [NREQ*WIDTH-1:0] Y_in,
  output logic [NREQ-1:0]       Ack,
  output logic [NREQ-1:0]       Done,
  output logic [WIDTH-1:0]      Gcd_out,
  output logic [IDW-1:0]        Grant_id,
  output logic                  Busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_xr, r_yr, r_gcd;
  logic [IDW-1:0]   r_grant, r_last;
  logic [NREQ-1:0]  r_ack, r_done;
  logic             r_busy;

  logic [WIDTH-1:0] w_xr_nxt, w_yr_nxt, w_gcd_nxt;
  logic [IDW-1:0]   w_grant_nxt, w_last_nxt;
  logic [NREQ-1:0]  w_ack_nxt, w_done_nxt;
  logic             w_found;
  logic [IDW-1:0]   w_gnt;
  logic             w_finish;

  // Round-robin search starting just after the most recent grantee.
  always_comb begin
    int v_idx;
    w_found = 1'b0;
    w_gnt   = '0;
    v_idx   = 0;
    for (int off = 1; off <= NREQ; off++) begin
      v_idx = int'(r_last) + off;
      if (v_idx >= NREQ) v_idx = v_idx - NREQ;
      if (!w_found && Req[v_idx]) begin
        w_found = 1'b1;
        w_gnt   = IDW'(v_idx);
      end
    end
  end

  assign w_finish = (r_xr == '0) || (r_yr == '0) || (r_xr == r_yr);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_RUN;
      S_RUN:   if (w_finish) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_xr_nxt    = r_xr;
    w_yr_nxt    = r_yr;
    w_gcd_nxt   = r_gcd;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_ack_nxt   = '0;
    w_done_nxt  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_xr_nxt    = X_in[int'(w_gnt)*WIDTH +: WIDTH];
          w_yr_nxt    = Y_in[int'(w_gnt)*WIDTH +: WIDTH];
          w_grant_nxt = w_gnt;
          w_last_nxt  = w_gnt;
          w_ack_nxt   = NREQ'(1) << w_gnt;
        end
      end
      S_RUN: begin
        if ((r_xr == '0) || (r_yr == '0)) begin
          w_gcd_nxt  = '0;
          w_done_nxt = NREQ'(1) << r_grant;
        end else if (r_xr == r_yr) begin
          w_gcd_nxt  = r_xr;
          w_done_nxt = NREQ'(1) << r_grant;
        end else if (r_xr > r_yr) begin
          w_xr_nxt = r_xr - r_yr;
        end else begin
          w_yr_nxt = r_yr - r_xr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_xr    <= '0;
      r_yr    <= '0;
      r_gcd   <= '0;
      r_grant <= '0;
      r_last  <= IDW'(NREQ - 1);
      r_ack   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_xr    <= w_xr_nxt;
      r_yr    <= w_yr_nxt;
      r_gcd   <= w_gcd_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_ack   <= w_ack_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign Ack      = r_ack;
  assign Done     = r_done;
  assign Gcd_out  = r_gcd;
  assign Grant_id = r_grant;
  assign Busy     = r_busy;

endmodule

// File: tb/tb_gcd_sched.sv
// Scoreboard bench for gcd_sched: drivers push expected results computed with
// Euclid's algorithm; a negedge monitor checks every Ack/Done pulse.
module tb_gcd_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  Clock = 1'b0;
  logic                  Reset_n = 1'b0;
  logic [NREQ-1:0]       Req = '0;
  logic [NREQ*WIDTH-1:0] X_in = '0;
  logic [NREQ*WIDTH-1:0] Y_in = '0;
  logic [NREQ-1:0]       Ack, Done;
  logic [WIDTH-1:0]      Gcd_out;
  logic [IDW-1:0]        Grant_id;
  logic                  Busy;

  gcd_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Req(Req), .X_in(X_in), .Y_in(Y_in),
    .Ack(Ack), .Done(Done), .Gcd_out(Gcd_out), .Grant_id(Grant_id), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  typedef struct {int id; int gcd; int k;} exp_t;
  exp_t sb[$];

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int ack_cyc [NREQ];
  bit in_flight = 0;
  bit gap = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input bit ok, input longint act, input longint exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference: gcd by Euclid; subtraction count = sum of quotients minus one.
  function automatic void ref_gcd(input int x, input int y, output int g, output int k);
    int a, b, t;
    if (x == 0 || y == 0) begin
      g = 0; k = 0;
    end else begin
      a = x; b = y; k = 0;
      while (b != 0) begin
        k += a / b;
        t = a % b;
        a = b;
        b = t;
      end
      g = a;
      k -= 1;
    end
  endfunction

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i] && r < 0) r = i;
    return r;
  endfunction

  always @(negedge Clock) begin
    int id;
    exp_t e;
    if (!Reset_n) begin
      in_flight = 0;
      gap = 0;
    end else begin
      if (gap) begin
        chk("gap_busy", Busy == 1'b0, Busy, 0);
        chk("gap_ack", Ack == '0, Ack, 0);
        gap = 0;
      end else if (in_flight) begin
        chk("busy_in_service", Busy == 1'b1, Busy, 1);
      end
      if (Ack != '0) begin
        chk("ack_onehot", $onehot(Ack), Ack, 0);
        id = oh_idx(Ack);
        ack_cyc[id] = cyc;
        in_flight = 1;
      end
      if (Done != '0) begin
        chk("done_onehot", $onehot(Done), Done, 0);
        id = oh_idx(Done);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1'b0, id, -1);
        end else begin
          e = sb.pop_front();
          chk("done_id", id == e.id, id, e.id);
          chk("gcd_out", Gcd_out == e.gcd[WIDTH-1:0], Gcd_out, e.gcd);
          chk("grant_id", Grant_id == e.id[IDW-1:0], Grant_id, e.id);
          chk("done_latency", cyc == ack_cyc[e.id] + e.k + 1, cyc - ack_cyc[e.id], e.k + 1);
        end
        in_flight = 0;
        gap = 1;
      end
    end
  end

  task automatic issue(input int id, input int x, input int y, input bit push);
    int g, k;
    X_in[id*WIDTH +: WIDTH] = x[WIDTH-1:0];
    Y_in[id*WIDTH +: WIDTH] = y[WIDTH-1:0];
    Req[id] = 1'b1;
    if (push) begin
      ref_gcd(x, y, g, k);
      sb.push_back('{id: id, gcd: g, k: k});
    end
  endtask

  task automatic wait_ack(input int id, input bit idle_at_issue);
    int t0 = cyc;
    bit seen = 0;
    for (int n = 0; n < 1200 && !seen; n++) begin
      @(negedge Clock);
      if (Ack[id]) seen = 1;
    end
    if (!seen) chk("ack_timeout", 1'b0, id, id);
    else if (idle_at_issue) chk("ack_latency", cyc == t0 + 1, cyc - t0, 1);
    Req[id] = 1'b0;
  endtask

  task automatic request(input int id, input int x, input int y);
    bit idle;
    idle = !Busy;
    issue(id, x, y, 1'b1);
    wait_ack(id, idle);
  endtask

  task automatic drain();
    for (int n = 0; n < 1200 && sb.size() != 0; n++) @(negedge Clock);
    if (sb.size() != 0) chk("drain_timeout", 1'b0, sb.size(), 0);
    repeat (2) @(negedge Clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, Busy == 1'b0, Busy, 0);
    chk({tag, "_ack"}, Ack == '0, Ack, 0);
    chk({tag, "_done"}, Done == '0, Done, 0);
    chk({tag, "_gcd"}, Gcd_out == '0, Gcd_out, 0);
    chk({tag, "_grant"}, Grant_id == '0, Grant_id, 0);
  endtask

  initial begin
    int id, x, y;
    repeat (3) @(negedge Clock);
    check_reset_outputs("reset");
    Reset_n = 1'b1;
    @(negedge Clock);

    // All four requesting from reset: served 0,1,2,3.
    for (int i = 0; i < NREQ; i++) issue(i, 64, 208, 1'b1);
    wait_ack(0, 1'b1);
    for (int i = 1; i < NREQ; i++) wait_ack(i, 1'b0);
    drain();

    // last==3: requester 0 wins over 3.
    issue(0, 45, 30, 1'b1);
    issue(3, 81, 27, 1'b1);
    wait_ack(0, 1'b1);
    wait_ack(3, 1'b0);
    drain();

    request(0, 6, 3);     drain();
    request(2, 255, 1);   drain();
    request(1, 0, 192);   drain();
    request(3, 28, 28);   drain();
    request(2, 192, 0);   drain();

    // Operand change after Ack must not affect the result.
    request(1, 12, 6);
    @(negedge Clock);
    X_in[1*WIDTH +: WIDTH] = 8'd99;
    Y_in[1*WIDTH +: WIDTH] = 8'd45;
    drain();

    for (int t = 0; t < 24; t++) begin
      id = $urandom_range(0, NREQ - 1);
      x = $urandom_range(0, 255);
      y = $urandom_range(1, 255);
      if ($urandom_range(0, 7) == 0) x = 0;
      request(id, x, y);
      drain();
    end

    // Reset in the middle of a long run: request lost, no Done.
    issue(0, 255, 1, 1'b0);
    wait_ack(0, 1'b1);
    repeat (49) @(negedge Clock);
    #2 Reset_n = 1'b0;
    #1 check_reset_outputs("midrun");
    repeat (2) @(negedge Clock);
    #2 Reset_n = 1'b1;
    @(negedge Clock);
    request(0, 158, 38);
    drain();
    repeat (300) @(negedge Clock);
    chk("sb_empty_end", sb.size() == 0, sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
